serial_tx: RTL

Parallel-in, serial-out transmitter: the driving end of a single-bit serial line whose far end is a clock-enabled D flip-flop chain sampling `d` on `clk` rising edges. It accepts `WIDTH`-bit words through a valid/ready handshake into a one-entry holding buffer. Each word is shifted out one bit per enabled clock on `q`, with `q_valid`/`q_last` framing. Back-to-back words stream with no idle gap.

---
 rtl/serial_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter.
// Words enter a one-entry holding buffer through a valid/ready handshake and
// are shifted out one bit per enabled clock on q, framed by q_valid/q_last.
// A word waiting in the holding buffer follows the current one with no gap.

module serial_tx #(
    parameter int WIDTH      = 8,     // bits per word, 2..32
    parameter bit MSB_FIRST  = 1'b1,  // 1: bit WIDTH-1 goes out first
    parameter bit IDLE_LEVEL = 1'b1   // line level when no word is sent
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             word_done;
    logic             load;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    bit_idx;
    logic             first_bit;
    logic             next_bit;

    // Accept needs an empty buffer and a drain needs a full one, so the two
    // can never coincide on one edge.
    assign accept    = d_valid && !hold_full;
    assign word_done = (state == SHIFT) && (cnt == LAST_IDX);
    assign load      = clk_en && hold_full && ((state == IDLE) || word_done);

    // Bit selection by position: the counter names the bit now on the line,
    // so the next bit is at position cnt+1 in transmit order.
    assign cnt_nxt   = cnt + CW'(1);
    assign bit_idx   = MSB_FIRST ? (LAST_IDX - cnt_nxt) : cnt_nxt;
    assign first_bit = MSB_FIRST ? hold[WIDTH-1] : hold[0];
    assign next_bit  = sr[bit_idx];

    assign d_ready = !hold_full;
    assign busy    = (state == SHIFT) || hold_full;

    // Holding buffer, shift engine and registered line outputs.
    // NOTE: every register here uses <= so all right-hand sides read the
    // pre-edge values; mixing in = would make the result order-dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            // NOTE: hold is a plain data register; resetting it costs little
            // and keeps simulation free of X on the data path after reset.
            hold      <= '0;
            hold_full <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            q         <= IDLE_LEVEL;
            q_valid   <= 1'b0;
            q_last    <= 1'b0;
        end else begin
            // Handshake runs every cycle, independent of the bit-rate enable.
            if (accept) begin
                hold      <= d;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (clk_en) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            sr      <= hold;
                            cnt     <= '0;
                            q       <= first_bit;
                            q_valid <= 1'b1;
                            q_last  <= 1'b0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cnt != LAST_IDX) begin
                            cnt    <= cnt_nxt;
                            q      <= next_bit;
                            q_last <= (cnt_nxt == LAST_IDX);
                        end else if (hold_full) begin
                            // Next word starts right behind the last bit.
                            sr      <= hold;
                            cnt     <= '0;
                            q       <= first_bit;
                            q_valid <= 1'b1;
                            q_last  <= 1'b0;
                        end else begin
                            q       <= IDLE_LEVEL;
                            q_valid <= 1'b0;
                            q_last  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
